// File: rtl/commit_trace_if.sv
// Bundle of commit-side inputs and aligned difftest-side outputs for commit_trace_align.
// Flow control: a lane is taken when in_valid[i]=1 and stall=0; out_valid is only ever shown on cycles with stall=0.
interface commit_trace_if #(
  parameter int NCH  = 2,
  parameter int XLEN = 64
);
  logic                stall;
  logic [NCH-1:0]      in_valid;
  logic [NCH*XLEN-1:0] in_pc;
  logic [NCH*32-1:0]   in_instr;
  logic [NCH-1:0]      in_wen;
  logic [NCH*5-1:0]    in_wdest;
  logic [NCH*XLEN-1:0] in_wdata;
  logic [NCH-1:0]      in_skip;
  logic [1:0]          in_mode;
  logic                in_trap;
  logic [2:0]          in_trap_code;

  logic [NCH-1:0]      out_valid;
  logic [NCH*XLEN-1:0] out_pc;
  logic [NCH*32-1:0]   out_instr;
  logic [NCH-1:0]      out_wen;
  logic [NCH*8-1:0]    out_wdest;
  logic [NCH*XLEN-1:0] out_wdata;
  logic [NCH-1:0]      out_skip;
  logic [1:0]          out_mode;
  logic                trap_valid;
  logic [2:0]          trap_code;
  logic [XLEN-1:0]     trap_pc;
  logic [63:0]         cycle_cnt;
  logic [63:0]         instr_cnt;
  logic [1:0]          fsm_state;

  modport master (
    output stall, in_valid, in_pc, in_instr, in_wen, in_wdest, in_wdata, in_skip,
           in_mode, in_trap, in_trap_code,
    input  out_valid, out_pc, out_instr, out_wen, out_wdest, out_wdata, out_skip,
           out_mode, trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, fsm_state
  );

  modport slave (
    input  stall, in_valid, in_pc, in_instr, in_wen, in_wdest, in_wdata, in_skip,
           in_mode, in_trap, in_trap_code,
    output out_valid, out_pc, out_instr, out_wen, out_wdest, out_wdata, out_skip,
           out_mode, trap_valid, trap_code, trap_pc, cycle_cnt, instr_cnt, fsm_state
  );
endinterface

// File: rtl/commit_trace_align.sv
// Delays commit lanes by DELAY cycles and privilege mode by MODE_LAG cycles so difftest
// probes see pc/instr/writeback/mode aligned; counts cycles/instructions and sequences halt.
module commit_trace_align #(
  parameter int NCH      = 2,
  parameter int XLEN     = 64,
  parameter int DELAY    = 2,
  parameter int MODE_LAG = 1
) (
  input logic           clk,
  input logic           reset,
  commit_trace_if.slave bus
);
  typedef struct packed {
    logic                      trap;
    logic [2:0]                code;
    logic [NCH-1:0]            valid;
    logic [NCH-1:0][XLEN-1:0]  pc;
    logic [NCH-1:0][31:0]      instr;
    logic [NCH-1:0]            wen;
    logic [NCH-1:0][4:0]       wdest;
    logic [NCH-1:0][XLEN-1:0]  wdata;
    logic [NCH-1:0]            skip;
  } bundle_t;

  typedef enum logic [1:0] {RUN = 2'd0, TRAP = 2'd1, HALTED = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            trap_hit;
  logic            shift_en;
  bundle_t         cap;
  bundle_t         st [DELAY];
  bundle_t         last;
  logic [XLEN-1:0] youngest_pc;
  logic [NCH-1:0]  vld_out;
  logic [63:0]     commit_cnt;
  logic [NCH*8-1:0] wdest_ext;
  logic [2:0]      trap_code_q;
  logic [XLEN-1:0] trap_pc_q;
  logic [63:0]     cycle_q, instr_q;

  // Once halted the chain is frozen so nothing past the halt can leak out.
  assign shift_en = !bus.stall && (state_q != HALTED);
  assign last     = st[DELAY-1];

  always_comb begin
    cap      = '0;
    cap.trap = bus.in_trap;
    cap.code = bus.in_trap ? bus.in_trap_code : 3'd0;
    for (int i = 0; i < NCH; i++) begin
      if (bus.in_valid[i]) begin
        cap.valid[i] = 1'b1;
        cap.pc[i]    = bus.in_pc[i*XLEN +: XLEN];
        cap.instr[i] = bus.in_instr[i*32 +: 32];
        cap.wen[i]   = bus.in_wen[i] && (bus.in_wdest[i*5 +: 5] != 5'd0);
        cap.wdest[i] = bus.in_wdest[i*5 +: 5];
        cap.wdata[i] = bus.in_wdata[i*XLEN +: XLEN];
        cap.skip[i]  = bus.in_skip[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DELAY; k++) st[k] <= '0;
    end else if (shift_en) begin
      st[0] <= cap;
      for (int k = 1; k < DELAY; k++) st[k] <= st[k-1];
    end
  end

  generate
    if (MODE_LAG == 0) begin : g_mode_comb
      assign bus.out_mode = bus.in_mode;
    end else begin : g_mode_reg
      logic [1:0] mode_st [MODE_LAG];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < MODE_LAG; k++) mode_st[k] <= 2'b11;
        end else if (shift_en) begin
          mode_st[0] <= bus.in_mode;
          for (int k = 1; k < MODE_LAG; k++) mode_st[k] <= mode_st[k-1];
        end
      end
      assign bus.out_mode = mode_st[MODE_LAG-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    trap_hit = 1'b0;
    case (state_q)
      RUN: begin
        if (last.trap && !bus.stall) begin
          state_d  = TRAP;
          trap_hit = 1'b1;
        end
      end
      TRAP:    state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    youngest_pc = '0;
    for (int i = 0; i < NCH; i++) begin
      if (last.valid[i]) youngest_pc = last.pc[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trap_code_q <= 3'd0;
      trap_pc_q   <= '0;
    end else if (trap_hit) begin
      trap_code_q <= last.code;
      trap_pc_q   <= youngest_pc;
    end
  end

  // Commits are shown only in RUN; bundles behind the halt instruction are dropped.
  assign vld_out = (state_q == RUN && !bus.stall) ? last.valid : '0;

  always_comb begin
    commit_cnt = '0;
    wdest_ext  = '0;
    for (int i = 0; i < NCH; i++) begin
      commit_cnt = commit_cnt + 64'(vld_out[i]);
      wdest_ext[i*8 +: 8] = {3'b000, last.wdest[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else if (state_q != HALTED) begin
      cycle_q <= cycle_q + 64'd1;
      instr_q <= instr_q + commit_cnt;
    end
  end

  assign bus.out_valid  = vld_out;
  assign bus.out_pc     = last.pc;
  assign bus.out_instr  = last.instr;
  assign bus.out_wen    = last.wen;
  assign bus.out_wdest  = wdest_ext;
  assign bus.out_wdata  = last.wdata;
  assign bus.out_skip   = last.skip;
  assign bus.trap_valid = (state_q == TRAP);
  assign bus.trap_code  = trap_code_q;
  assign bus.trap_pc    = trap_pc_q;
  assign bus.cycle_cnt  = cycle_q;
  assign bus.instr_cnt  = instr_q;
  assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_commit_trace_align.sv
// Bench for commit_trace_align: directed alignment/stall/mode/reset/halt cases plus a random
// stream checked through an expected-bundle queue.
module tb_commit_trace_align;
  localparam int NCH      = 2;
  localparam int XLEN     = 64;
  localparam int DELAY    = 2;
  localparam int MODE_LAG = 1;
  localparam int W        = NCH * (3 + 2*XLEN + 40);

  typedef logic [383:0] cv_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_vec = 0;
  int n_err = 0;
  int tb_cyc = 0;
  int rel = 0;
  int seen_cnt = 0;
  int s0 = 0;
  int froz = 0;
  logic [63:0] exp_instr = '0;
  logic [W-1:0] exp_q[$];

  commit_trace_if #(.NCH(NCH), .XLEN(XLEN)) bus();

  commit_trace_align #(.NCH(NCH), .XLEN(XLEN), .DELAY(DELAY), .MODE_LAG(MODE_LAG)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // clock / reset timing
  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", tb_cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input cv_t got, input cv_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] obs();
    return {bus.out_valid, bus.out_pc, bus.out_instr, bus.out_wen, bus.out_wdest,
            bus.out_wdata, bus.out_skip};
  endfunction

  // driver: sets one input bundle and, when it will be sampled, queues its sanitised image
  task automatic drive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1,
                       input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] wen,
                       input logic [4:0] d0, input logic [4:0] d1, input logic [63:0] w0,
                       input logic [63:0] w1, input logic [1:0] sk, input logic trap,
                       input logic [2:0] code, input bit push);
    logic [W-1:0] e;
    bus.in_valid     = v;
    bus.in_pc        = {pc1, pc0};
    bus.in_instr     = {i1, i0};
    bus.in_wen       = wen;
    bus.in_wdest     = {d1, d0};
    bus.in_wdata     = {w1, w0};
    bus.in_skip      = sk;
    bus.in_trap      = trap;
    bus.in_trap_code = code;
    if (push && !bus.stall && v != 2'b00) begin
      e = {v,
           v[1] ? pc1 : 64'h0, v[0] ? pc0 : 64'h0,
           v[1] ? i1 : 32'h0, v[0] ? i0 : 32'h0,
           {wen[1] & v[1] & (d1 != 5'd0), wen[0] & v[0] & (d0 != 5'd0)},
           v[1] ? {3'b000, d1} : 8'h00, v[0] ? {3'b000, d0} : 8'h00,
           v[1] ? w1 : 64'h0, v[0] ? w0 : 64'h0,
           sk & v};
      exp_q.push_back(e);
      exp_instr = exp_instr + 64'(v[0]) + 64'(v[1]);
    end
  endtask

  task automatic idle();
    drive(2'b00, 64'h0, 64'h0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic drive_rand(input bit push);
    logic [4:0] d0, d1;
    d0 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    d1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    drive(2'($urandom_range(0, 3)), {$urandom(), $urandom()}, {$urandom(), $urandom()},
          $urandom(), $urandom(), 2'($urandom_range(0, 3)), d0, d1,
          {$urandom(), $urandom()}, {$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
          1'b0, 3'd0, push);
  endtask

  // scoreboard: every presented commit must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && bus.out_valid != '0) begin
      seen_cnt++;
      if (exp_q.size() == 0) check("unexpected_commit", cv_t'(obs()), cv_t'(0));
      else                   check("bundle", cv_t'(obs()), cv_t'(exp_q.pop_front()));
    end
  end

  initial begin
    bus.stall   = 1'b0;
    bus.in_mode = 2'b11;
    idle();
    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;
    rel = tb_cyc;
    sample();
    check("rst_out_valid", cv_t'(bus.out_valid), cv_t'(0));
    check("rst_trap_valid", cv_t'(bus.trap_valid), cv_t'(0));
    check("rst_cycle_cnt", cv_t'(bus.cycle_cnt), cv_t'(0));
    check("rst_instr_cnt", cv_t'(bus.instr_cnt), cv_t'(0));
    check("rst_out_mode", cv_t'(bus.out_mode), cv_t'(2'b11));

    // single lane, DELAY-cycle latency, shown exactly once
    cyc();
    drive(2'b01, 64'h8000_0000, 64'h0, 32'h0000_0013, 32'h0, 2'b00, 5'd0, 5'd0,
          64'h0, 64'h0, 2'b00, 1'b0, 3'd0, 1'b1);
    cyc(); idle();
    sample(); check("t1_early", cv_t'(bus.out_valid), cv_t'(0));
    cyc(); sample();
    check("t1_valid", cv_t'(bus.out_valid), cv_t'(2'b01));
    check("t1_pc", cv_t'(bus.out_pc[63:0]), cv_t'(64'h8000_0000));
    cyc(); sample();
    check("t1_once", cv_t'(bus.out_valid), cv_t'(0));
    check("t1_instr_cnt", cv_t'(bus.instr_cnt), cv_t'(1));
    check("t1_cycle_cnt", cv_t'(bus.cycle_cnt), cv_t'(tb_cyc - rel));

    // write-enable sanitising against x0
    cyc();
    drive(2'b11, 64'h8000_0004, 64'h8000_0008, 32'h0000_0093, 32'h0010_0293, 2'b11, 5'd0, 5'd5,
          64'hdead, 64'h1234, 2'b00, 1'b0, 3'd0, 1'b1);
    cyc(); idle();
    cyc(); sample();
    check("t2_wen", cv_t'(bus.out_wen), cv_t'(2'b10));
    check("t2_wdest1", cv_t'(bus.out_wdest[15:8]), cv_t'(8'h05));
    check("t2_wdest0", cv_t'(bus.out_wdest[7:0]), cv_t'(8'h00));
    check("t2_wdata1", cv_t'(bus.out_wdata[127:64]), cv_t'(64'h1234));
    cyc(); sample();
    check("t2_instr_cnt", cv_t'(bus.instr_cnt), cv_t'(3));

    // lane 1 valid with lane 0 invalid: lane 0 fields zeroed, no compaction
    cyc();
    drive(2'b10, 64'hffff_0000, 64'h8000_000c, 32'hffff_ffff, 32'h0000_0073, 2'b11, 5'd7, 5'd0,
          64'hbeef, 64'h55, 2'b11, 1'b0, 3'd0, 1'b1);
    cyc(); idle();
    cyc(); sample();
    check("l1_valid", cv_t'(bus.out_valid), cv_t'(2'b10));
    check("l1_lane0_pc", cv_t'(bus.out_pc[63:0]), cv_t'(0));
    cyc(); sample();
    check("l1_instr_cnt", cv_t'(bus.instr_cnt), cv_t'(4));

    // stall while the bundle sits in the last stage
    cyc();
    drive(2'b01, 64'h8000_0200, 64'h0, 32'h0000_0513, 32'h0, 2'b01, 5'd10, 5'd0,
          64'h77, 64'h0, 2'b01, 1'b0, 3'd0, 1'b1);
    cyc(); idle();
    cyc();
    bus.stall = 1'b1;
    s0 = seen_cnt;
    for (int k = 0; k < 3; k++) begin
      sample(); check("t3_stalled", cv_t'(bus.out_valid), cv_t'(0));
      cyc();
    end
    bus.stall = 1'b0;
    sample(); check("t3_release", cv_t'(bus.out_valid), cv_t'(2'b01));
    cyc();
    repeat (3) begin sample(); cyc(); end
    check("t3_once", cv_t'(seen_cnt - s0), cv_t'(1));
    sample();
    check("t3_cycle_cnt", cv_t'(bus.cycle_cnt), cv_t'(tb_cyc - rel));
    check("t3_instr_cnt", cv_t'(bus.instr_cnt), cv_t'(5));

    // mode lag, then mode change under a 2-cycle stall
    cyc();
    bus.in_mode = 2'b00;
    sample(); check("t6_before", cv_t'(bus.out_mode), cv_t'(2'b11));
    cyc(); sample(); check("t6_after", cv_t'(bus.out_mode), cv_t'(2'b00));
    cyc();
    bus.in_mode = 2'b11;
    bus.stall = 1'b1;
    sample(); check("t6_stall_m0", cv_t'(bus.out_mode), cv_t'(2'b00));
    cyc(); sample(); check("t6_stall_m1", cv_t'(bus.out_mode), cv_t'(2'b00));
    cyc();
    bus.stall = 1'b0;
    sample(); check("t6_stall_m2", cv_t'(bus.out_mode), cv_t'(2'b00));
    cyc(); sample(); check("t6_stall_m3", cv_t'(bus.out_mode), cv_t'(2'b11));

    // random stream with random stalls
    for (int n = 0; n < 200; n++) begin
      cyc();
      bus.stall = ($urandom_range(0, 3) == 0);
      drive_rand(1'b1);
    end
    cyc();
    bus.stall = 1'b0;
    idle();
    repeat (DELAY + 2) cyc();
    sample();
    check("rand_drained", cv_t'(exp_q.size()), cv_t'(0));
    check("rand_instr_cnt", cv_t'(bus.instr_cnt), cv_t'(exp_instr));
    check("rand_cycle_cnt", cv_t'(bus.cycle_cnt), cv_t'(tb_cyc - rel));

    // reset with two bundles in flight
    cyc();
    bus.in_mode = 2'b00;
    drive(2'b11, 64'h8000_0300, 64'h8000_0304, 32'h1, 32'h2, 2'b11, 5'd1, 5'd2,
          64'h1, 64'h2, 2'b00, 1'b0, 3'd0, 1'b1);
    cyc();
    drive(2'b01, 64'h8000_0308, 64'h0, 32'h3, 32'h0, 2'b01, 5'd3, 5'd0,
          64'h3, 64'h0, 2'b00, 1'b0, 3'd0, 1'b1);
    cyc();
    bus.stall = 1'b1;
    idle();
    sample(); check("t5_mode_pre", cv_t'(bus.out_mode), cv_t'(2'b00));
    cyc();
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.in_mode = 2'b11;
    exp_q.delete();
    exp_instr = '0;
    s0 = seen_cnt;
    cyc();
    reset = 1'b0;
    rel = tb_cyc;
    sample();
    check("t5_out_valid", cv_t'(bus.out_valid), cv_t'(0));
    check("t5_cycle_cnt", cv_t'(bus.cycle_cnt), cv_t'(0));
    check("t5_instr_cnt", cv_t'(bus.instr_cnt), cv_t'(0));
    check("t5_out_mode", cv_t'(bus.out_mode), cv_t'(2'b11));
    repeat (4) begin cyc(); sample(); end
    check("t5_flushed", cv_t'(seen_cnt - s0), cv_t'(0));

    // halt: commit, trap event one cycle later, then frozen
    cyc();
    drive(2'b01, 64'h8000_0100, 64'h0, 32'h0000_006b, 32'h0, 2'b00, 5'd0, 5'd0,
          64'h0, 64'h0, 2'b00, 1'b1, 3'd0, 1'b1);
    cyc();
    drive(2'b11, 64'h8000_0104, 64'h8000_0108, 32'h13, 32'h13, 2'b11, 5'd1, 5'd2,
          64'h9, 64'h9, 2'b00, 1'b0, 3'd0, 1'b0);
    cyc(); idle();
    sample();
    check("t4_commit", cv_t'(bus.out_valid), cv_t'(2'b01));
    check("t4_trap_early", cv_t'(bus.trap_valid), cv_t'(0));
    cyc(); sample();
    check("t4_trap_valid", cv_t'(bus.trap_valid), cv_t'(1));
    check("t4_trap_pc", cv_t'(bus.trap_pc), cv_t'(64'h8000_0100));
    check("t4_trap_code", cv_t'(bus.trap_code), cv_t'(3'd0));
    check("t4_gated", cv_t'(bus.out_valid), cv_t'(0));
    cyc(); sample();
    check("t4_trap_once", cv_t'(bus.trap_valid), cv_t'(0));
    froz = tb_cyc - rel;
    check("t4_cycle_cnt", cv_t'(bus.cycle_cnt), cv_t'(froz));
    for (int n = 0; n < 6; n++) begin
      cyc();
      drive_rand(1'b0);
      sample();
      check("t4_frozen", cv_t'(bus.cycle_cnt), cv_t'(froz));
      check("t4_no_trap", cv_t'(bus.trap_valid), cv_t'(0));
    end
    check("t4_instr_cnt", cv_t'(bus.instr_cnt), cv_t'(exp_instr));
    check("t4_drained", cv_t'(exp_q.size()), cv_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
